// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the decode-stage control unit: opcodes, ALU operation
// classes and the control bundle carried from ID into EX.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Encoding consumed by the ALU control decoder in EX.
    typedef enum logic [1:0] {
        ADD   = 2'b00,
        SUB   = 2'b01,
        FUNCT = 2'b10,
        OR    = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_dst;
        logic    alu_src;
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(10'd0);

    // Opcodes whose rt field is a source operand (and so can hit a pending load).
    function automatic logic reads_rt(input logic [5:0] opcode);
        logic result;
        case (opcode)
            OP_RTYPE: result = 1'b1;
            OP_BEQ:   result = 1'b1;
            OP_SW:    result = 1'b1;
            default:  result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/id_ex_control_stage_main_decoder.sv
// Combinational main decoder: opcode to control bundle plus an illegal flag.
module main_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    // Table lookup of the control bundle; unknown opcodes decode to a bubble.
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = FUNCT;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = SUB;
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ADD;
            end
            OP_ORI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = OR;
            end
            OP_J: begin
                ctrl.jump   = 1'b1;
                ctrl.alu_op = ADD;
            end
            default: begin
                ctrl    = CTRL_BUBBLE;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_control_stage.sv
// ID-stage control unit with the ID/EX pipeline register, load-use hazard
// detection, and bubble insertion on hazard, flush or illegal opcode.
module id_ex_control_stage
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        idValid,
    input  logic [31:0] idInstr,
    input  logic        flush,
    input  logic        hold,
    output logic        stallIfId,
    output logic        exValid,
    output logic        exRegDst,
    output logic        exAluSrc,
    output logic        exMemToReg,
    output logic        exRegWrite,
    output logic        exMemRead,
    output logic        exMemWrite,
    output logic        exBranch,
    output logic        exJump,
    output logic [1:0]  exAluOp,
    output logic [5:0]  exFunct,
    output logic [4:0]  exRs,
    output logic [4:0]  exRt,
    output logic [4:0]  exRd,
    output logic        exIllegal
);

    logic [5:0] opcode_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    ctrl_t      dec_ctrl_s;
    logic       dec_illegal_s;
    logic       load_use_s;
    logic       unused_shamt_s;

    logic       ex_valid_r;
    ctrl_t      ex_ctrl_r;
    logic [5:0] ex_funct_r;
    logic [4:0] ex_rs_r;
    logic [4:0] ex_rt_r;
    logic [4:0] ex_rd_r;
    logic       ex_illegal_r;

    assign opcode_s       = idInstr[31:26];
    assign rs_s           = idInstr[25:21];
    assign rt_s           = idInstr[20:16];
    assign unused_shamt_s = ^idInstr[10:6];

    main_decoder u_main_decoder (
        .opcode  (opcode_s),
        .ctrl    (dec_ctrl_s),
        .illegal (dec_illegal_s)
    );

    // A load in EX whose target is read by the ID instruction; $0 never conflicts.
    assign load_use_s = ex_valid_r & ex_ctrl_r.mem_read & idValid &
                        (ex_rt_r != 5'd0) &
                        ((ex_rt_r == rs_s) | ((ex_rt_r == rt_s) & reads_rt(opcode_s)));

    // A flush squashes the dependent instruction and hold freezes the front end anyway.
    assign stallIfId = load_use_s & ~hold & ~flush;

    // ID/EX register: hold freezes, flush/hazard/empty/illegal insert a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_r   <= 1'b0;
            ex_ctrl_r    <= CTRL_BUBBLE;
            ex_funct_r   <= 6'd0;
            ex_rs_r      <= 5'd0;
            ex_rt_r      <= 5'd0;
            ex_rd_r      <= 5'd0;
            ex_illegal_r <= 1'b0;
        end else if (hold) begin
            ex_valid_r   <= ex_valid_r;
            ex_ctrl_r    <= ex_ctrl_r;
            ex_funct_r   <= ex_funct_r;
            ex_rs_r      <= ex_rs_r;
            ex_rt_r      <= ex_rt_r;
            ex_rd_r      <= ex_rd_r;
            ex_illegal_r <= ex_illegal_r;
        end else if (flush | load_use_s | ~idValid | dec_illegal_s) begin
            ex_valid_r   <= 1'b0;
            ex_ctrl_r    <= CTRL_BUBBLE;
            ex_funct_r   <= 6'd0;
            ex_rs_r      <= 5'd0;
            ex_rt_r      <= 5'd0;
            ex_rd_r      <= 5'd0;
            ex_illegal_r <= ~flush & ~load_use_s & idValid & dec_illegal_s;
        end else begin
            ex_valid_r   <= 1'b1;
            ex_ctrl_r    <= dec_ctrl_s;
            ex_funct_r   <= idInstr[5:0];
            ex_rs_r      <= rs_s;
            ex_rt_r      <= rt_s;
            ex_rd_r      <= idInstr[15:11];
            ex_illegal_r <= 1'b0;
        end
    end

    assign exValid    = ex_valid_r;
    assign exRegDst   = ex_ctrl_r.reg_dst;
    assign exAluSrc   = ex_ctrl_r.alu_src;
    assign exMemToReg = ex_ctrl_r.mem_to_reg;
    assign exRegWrite = ex_ctrl_r.reg_write;
    assign exMemRead  = ex_ctrl_r.mem_read;
    assign exMemWrite = ex_ctrl_r.mem_write;
    assign exBranch   = ex_ctrl_r.branch;
    assign exJump     = ex_ctrl_r.jump;
    assign exAluOp    = ex_ctrl_r.alu_op;
    assign exFunct    = ex_funct_r;
    assign exRs       = ex_rs_r;
    assign exRt       = ex_rt_r;
    assign exRd       = ex_rd_r;
    assign exIllegal  = ex_illegal_r;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a table-driven reference model of the decode/hazard rules.
module tb_id_ex_control_stage;

    logic        clk;
    logic        reset;
    logic        idValid;
    logic [31:0] idInstr;
    logic        flush;
    logic        hold;
    logic        stallIfId;
    logic        exValid, exRegDst, exAluSrc, exMemToReg, exRegWrite;
    logic        exMemRead, exMemWrite, exBranch, exJump;
    logic [1:0]  exAluOp;
    logic [5:0]  exFunct;
    logic [4:0]  exRs, exRt, exRd;
    logic        exIllegal;

    int total = 0;
    int bad   = 0;

    // Reference state: what EX should hold.
    logic        m_valid;
    logic [9:0]  m_ctrl;   // RegDst,AluSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,Jump,AluOp[1:0]
    logic [5:0]  m_funct;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        m_ill;
    logic        last_stall;
    logic        prev_stall;
    logic [31:0] cur_instr;

    id_ex_control_stage dut (
        .clk(clk), .reset(reset), .idValid(idValid), .idInstr(idInstr),
        .flush(flush), .hold(hold), .stallIfId(stallIfId), .exValid(exValid),
        .exRegDst(exRegDst), .exAluSrc(exAluSrc), .exMemToReg(exMemToReg),
        .exRegWrite(exRegWrite), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
        .exBranch(exBranch), .exJump(exJump), .exAluOp(exAluOp), .exFunct(exFunct),
        .exRs(exRs), .exRt(exRt), .exRd(exRd), .exIllegal(exIllegal)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Control table straight from the instruction list: {legal, bundle}.
    function automatic logic [10:0] ref_decode(input logic [5:0] op);
        case (op)
            6'h00:   return {1'b1, 10'b1001000010};
            6'h23:   return {1'b1, 10'b0111100000};
            6'h2b:   return {1'b1, 10'b0100010000};
            6'h04:   return {1'b1, 10'b0000001001};
            6'h08:   return {1'b1, 10'b0101000000};
            6'h0d:   return {1'b1, 10'b0101000011};
            6'h02:   return {1'b1, 10'b0000000100};
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic ref_load_use(input logic v, input logic [31:0] ins);
        logic [5:0] op;
        logic       rt_src;
        op     = ins[31:26];
        rt_src = (op == 6'h00) || (op == 6'h04) || (op == 6'h2b);
        return m_valid && m_ctrl[5] && v && (m_rt != 5'd0) &&
               ((m_rt == ins[25:21]) || ((m_rt == ins[20:16]) && rt_src));
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({exValid, exRegDst, exAluSrc, exMemToReg, exRegWrite, exMemRead,
                    exMemWrite, exBranch, exJump, exAluOp, exFunct, exRs, exRt, exRd, exIllegal});
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({m_valid, m_ctrl, m_funct, m_rs, m_rt, m_rd, m_ill});
    endfunction

    task automatic model_bubble(input logic ill);
        m_valid = 1'b0; m_ctrl = 10'd0; m_funct = 6'd0;
        m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_ill = ill;
    endtask

    // One pipeline cycle: drive at negedge, check stall, advance model, check EX.
    task automatic do_cycle(input logic v, input logic [31:0] ins, input logic fl, input logic hd);
        logic        lu;
        logic [10:0] dec;
        @(negedge clk);
        idValid = v; idInstr = ins; flush = fl; hold = hd;
        #1;
        lu = ref_load_use(v, ins);
        last_stall = lu & ~hd & ~fl;
        chk("stall", 64'(stallIfId), 64'(last_stall));
        dec = ref_decode(ins[31:26]);
        if (hd) begin
            // frozen
        end else if (fl || lu || !v) begin
            model_bubble(1'b0);
        end else if (!dec[10]) begin
            model_bubble(1'b1);
        end else begin
            m_valid = 1'b1; m_ctrl = dec[9:0]; m_funct = ins[5:0];
            m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11]; m_ill = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ex_bundle", dut_vec(), model_vec());
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] op;
        case ($urandom_range(0, 9))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h23;
            3: op = 6'h2b;
            4: op = 6'h04;
            5: op = 6'h08;
            6: op = 6'h0d;
            7: op = 6'h02;
            8: op = 6'h3f;
            default: op = 6'h20;
        endcase
        return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    initial begin
        reset = 1'b1; idValid = 1'b0; idInstr = 32'd0; flush = 1'b0; hold = 1'b0;
        last_stall = 1'b0;
        model_bubble(1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_bundle", dut_vec(), 64'd0);
        chk("reset_stall", 64'(stallIfId), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type add $8,$9,$10
        do_cycle(1'b1, 32'h012A4020, 1'b0, 1'b0);
        chk("rtype_regdst", 64'(exRegDst), 64'd1);
        chk("rtype_regwrite", 64'(exRegWrite), 64'd1);
        chk("rtype_aluop", 64'(exAluOp), 64'd2);
        chk("rtype_funct", 64'(exFunct), 64'h20);
        chk("rtype_rd", 64'(exRd), 64'd8);

        // lw $8 then add using $8: one stall, one bubble, then the add
        do_cycle(1'b1, 32'h8D280000, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h01095020, 1'b0, 1'b0);
        chk("lu_stall", 64'(last_stall), 64'd1);
        chk("lu_bubble", 64'(exValid), 64'd0);
        do_cycle(1'b1, 32'h01095020, 1'b0, 1'b0);
        chk("lu_release", 64'(last_stall), 64'd0);
        chk("lu_add_valid", 64'(exValid), 64'd1);
        // load into $0 never stalls
        do_cycle(1'b1, 32'h8D200000, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h00005020, 1'b0, 1'b0);
        chk("lu_rt0_nostall", 64'(last_stall), 64'd0);

        // flush of an ori, then flush on top of a hazard
        do_cycle(1'b1, 32'h35080005, 1'b1, 1'b0);
        chk("flush_valid", 64'(exValid), 64'd0);
        chk("flush_aluop", 64'(exAluOp), 64'd0);
        do_cycle(1'b1, 32'h8D280000, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h01095020, 1'b1, 1'b0);
        chk("flush_hazard_stall", 64'(last_stall), 64'd0);

        // beq registered, then held three cycles with a dependent-looking instr
        do_cycle(1'b1, 32'h11090003, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 32'h8D280000, 1'b0, 1'b1);
            chk("hold_branch", 64'(exBranch), 64'd1);
            chk("hold_aluop", 64'(exAluOp), 64'd1);
            chk("hold_stall", 64'(last_stall), 64'd0);
        end
        // lw in EX while held against a dependent add: no stall, then stall after release
        do_cycle(1'b1, 32'h8D280000, 1'b0, 1'b0);
        do_cycle(1'b1, 32'h01095020, 1'b0, 1'b1);
        do_cycle(1'b1, 32'h01095020, 1'b0, 1'b0);
        chk("hold_then_stall", 64'(last_stall), 64'd1);
        do_cycle(1'b1, 32'h01095020, 1'b0, 1'b0);

        // illegal opcode: one-cycle flag, cleared by the next valid instruction
        do_cycle(1'b1, 32'hFC000000, 1'b0, 1'b0);
        chk("illegal_flag", 64'(exIllegal), 64'd1);
        chk("illegal_valid", 64'(exValid), 64'd0);
        do_cycle(1'b1, 32'h012A4020, 1'b0, 1'b0);
        chk("illegal_clear", 64'(exIllegal), 64'd0);

        // asynchronous reset in the middle of a stall
        do_cycle(1'b1, 32'h8D280000, 1'b0, 1'b0);
        @(negedge clk);
        idValid = 1'b1; idInstr = 32'h01095020; flush = 1'b0; hold = 1'b0;
        #1;
        chk("pre_reset_stall", 64'(stallIfId), 64'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_bundle", dut_vec(), 64'd0);
        chk("async_reset_stall", 64'(stallIfId), 64'd0);
        model_bubble(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // randomized traffic; a stalled instruction stays in IF/ID
        prev_stall = 1'b0;
        cur_instr  = rand_instr();
        for (int i = 0; i < 2000; i++) begin
            if (!prev_stall) cur_instr = rand_instr();
            do_cycle(($urandom_range(0, 9) != 0), cur_instr,
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            prev_stall = last_stall;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_control_stage.md
# id_ex_control_stage

Decode-stage main control unit with its ID/EX pipeline register. Decodes the 32-bit instruction held in IF/ID into the datapath control bundle and registers it for EX. That bundle includes the 2-bit ALU operation class and the 6-bit function field that the ALU control decoder consumes in EX. Detects load-use hazards against its own registered state, inserts bubbles on hazard, flush or illegal opcode, and freezes on external hold.

## Interface
Parameters:
- none; all encodings come from `mips_ctrl_pkg`.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `idValid`  in  1  IF/ID holds a real instruction.
- `idInstr`  in  32  instruction in IF/ID.
- `flush`  in  1  taken branch or jump; squash the ID-stage instruction.
- `hold`  in  1  global pipeline freeze, for example a memory wait.
- `stallIfId`  out  1  combinational; hold PC and IF/ID this cycle (load-use).
- `exValid`  out  1  EX slot holds a real instruction.
- `exRegDst`, `exAluSrc`, `exMemToReg`, `exRegWrite`, `exMemRead`, `exMemWrite`, `exBranch`, `exJump`  out  1 each  registered control bits.
- `exAluOp`  out  2  ALU operation class: 00 add, 01 sub, 10 use funct, 11 or.
- `exFunct`  out  6  `idInstr[5:0]`, registered.
- `exRs`, `exRt`, `exRd`  out  5 each  `idInstr[25:21]`, `[20:16]`, `[15:11]`, registered.
- `exIllegal`  out  1  registered one-cycle flag: the ID instruction had an unknown opcode.

## Operation
Decode from `idInstr[31:26]`; bits are listed as RegDst, AluSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump, then AluOp:
- 000000 R-type: 1,0,0,1,0,0,0,0, AluOp 10.
- 100011 lw: 0,1,1,1,1,0,0,0, AluOp 00.
- 101011 sw: 0,1,0,0,0,1,0,0, AluOp 00.
- 000100 beq: 0,0,0,0,0,0,1,0, AluOp 01.
- 001000 addi: 0,1,0,1,0,0,0,0, AluOp 00.
- 001101 ori: 0,1,0,1,0,0,0,0, AluOp 11.
- 000010 j: all control bits 0 except Jump=1, AluOp 00.
- Any other opcode: illegal.

Bubble:
- `exValid`=0, all control bits 0, `exAluOp`=00.
- `exFunct`, `exRs`, `exRt`, `exRd` = 0.

Load-use hazard (combinational), `loadUse` = `exValid & exMemRead & idValid & (exRt != 0)` & ((`exRt`==`idInstr[25:21]`) | (`exRt`==`idInstr[20:16]` & opcode ∈ {R-type, beq, sw})).
- `stallIfId` = `loadUse & ~hold & ~flush`.

Per-edge update, priority high to low:
1. `reset`: bubble, `exIllegal`=0.
2. `hold`: every register keeps its value, including `exIllegal`.
3. `flush`: bubble, `exIllegal`=0.
4. `loadUse`: bubble, `exIllegal`=0. IF/ID is held by `stallIfId`, so the instruction is re-decoded next cycle.
5. `~idValid`: bubble, `exIllegal`=0.
6. Illegal opcode: bubble, `exIllegal`=1.
7. Otherwise: load the decoded bundle, `exValid`=1, `exIllegal`=0.

Boundary rules:
- `exRt`==0 never stalls.
- `flush` together with `loadUse`: no stall, bubble only.
- `hold` with `loadUse`: no stall assertion, state frozen; the hazard re-evaluates after `hold` drops.
- Back-to-back lw→lw dependency stalls exactly one cycle per dependency.

## Timing
- Latency: one cycle, ID in to EX out.
- `stallIfId` is valid in the same cycle as `idInstr`.
- Asynchronous reset: outputs go to the bubble values immediately on assertion, with `exIllegal`=0 and `stallIfId`=0. Reset asserted mid-stall clears the hazard source in the same cycle.
- `exIllegal` asserts for exactly one cycle per illegal instruction, unless `hold` extends it.

## Structure
- `mips_ctrl_pkg` holds:
  - opcode localparams.
  - `alu_op_e` enum (ADD=2'b00, SUB=2'b01, FUNCT=2'b10, OR=2'b11), matching the encoding the ALU control decoder consumes.
  - `ctrl_t` packed struct for the control bundle, and a `CTRL_BUBBLE` constant.
- Sub-module `main_decoder`: combinational, maps opcode to {`ctrl_t`, illegal}. The top level holds the hazard logic and the pipeline register.

## Test plan
- Reset mid-operation: drive a valid R-type, assert `reset` between edges → all outputs 0 immediately, without waiting for a clock edge.
- R-type add `0x012A4020` (add $8,$9,$10) → next cycle `exRegDst`=1, `exRegWrite`=1, `exAluOp`=10, `exFunct`=6'h20, `exRd`=8.
- Load-use: lw $8 (`0x8D280000`) then add with rs=$8 → `stallIfId`=1 for one cycle; one bubble reaches EX, then the add with `exValid`=1. With rt=$0 as the load target, no stall.
- Flush: assert `flush` while ori is in ID → next cycle bubble with `exAluOp`=00. `flush` together with a hazard → `stallIfId`=0.
- Hold: assert `hold` for 3 cycles after a beq is registered → `exBranch`=1 and `exAluOp`=01 stable all 3 cycles, `stallIfId`=0.
- Illegal opcode 6'b111111 → bubble, `exIllegal`=1 for one cycle, then 0 on the following valid instruction.
